// File: rtl/enemy_kill_tracker.sv
// enemy_kill_tracker: one kill per enemy life, BCD score, lives, PLAY/WIN/OVER FSM.
// Optional combo scoring is built when ENEMY_KILL_COMBO_EN is defined.
module enemy_kill_tracker #(
  parameter int          N_ENEMY         = 3,
  parameter int          KILLS_TO_WIN    = 20,
  parameter int          LIVES_INIT      = 3,
  parameter logic [15:0] POINTS_PER_KILL = 16'h0100,
  parameter int          COMBO_WINDOW    = 60
) (
  input  logic               clk_50MHz,
  input  logic               reset,
  input  logic               refresh_tick,
  input  logic               restart,
  input  logic [N_ENEMY-1:0] enemy_detroyed,
  input  logic [N_ENEMY-1:0] reset_loc,
  input  logic               tank_detroyed,
  output logic [15:0]        score_bcd,
  output logic [7:0]         kills,
  output logic [1:0]         lives,
  output logic [1:0]         game_state,
  output logic               game_active,
  output logic [N_ENEMY-1:0] kill_pulse
);

  typedef enum logic [1:0] {
    PLAY = 2'b00,
    WIN  = 2'b01,
    OVER = 2'b10
  } state_t;

  localparam logic [7:0] WIN_KILLS = 8'(KILLS_TO_WIN);
  localparam logic [1:0] LIVES_RST = 2'(LIVES_INIT);

  state_t             state;
  logic [N_ENEMY-1:0] ed_prev;
  logic [N_ENEMY-1:0] armed;
  logic [N_ENEMY-1:0] pend;
  logic               tank_prev;

  logic [N_ENEMY-1:0] rise;
  logic [N_ENEMY-1:0] accept;
  logic [N_ENEMY-1:0] cand;
  logic [N_ENEMY-1:0] sel;
  logic [N_ENEMY-1:0] armed_nxt;
  logic               tank_rise;
  logic               play;
  logic               any_kill;
  logic               to_over;
  logic               to_win;
  logic [15:0]        pts;
  logic [15:0]        score_sum;
  logic [7:0]         kills_sum;
  logic [7:0]         kills_nxt;
  logic [1:0]         lives_dec;
  logic [1:0]         lives_nxt;

  function automatic logic [15:0] bcd_add(
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic [15:0] s;
    logic [4:0]  d;
    logic        c;
    s = '0;
    c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, a[4*i +: 4]}
        + {1'b0, b[4*i +: 4]}
        + {4'd0, c};
      c = (d > 5'd9);
      if (c) d = d + 5'd6;
      s[4*i +: 4] = d[3:0];
    end
    return c ? 16'h9999 : s;
  endfunction

  assign game_state = state;

  // Edge detection, arming and the lowest-index kill selection.
  always_comb begin
    play      = (state == PLAY);
    rise      = enemy_detroyed & ~ed_prev;
    tank_rise = tank_detroyed & ~tank_prev;
    accept    = rise & armed & {N_ENEMY{play}};
    cand      = pend | accept;
    sel       = cand & (~cand + N_ENEMY'(1));
    any_kill  = |cand;
    armed_nxt = (armed & ~accept)
              | (reset_loc & ~rise);
    score_sum = bcd_add(score_bcd, pts);
    kills_sum = (kills == 8'hFF) ? kills
              : kills + 8'd1;
    lives_dec = (lives == 2'd0) ? lives
              : lives - 2'd1;
    kills_nxt = any_kill ? kills_sum : kills;
    lives_nxt = tank_rise ? lives_dec : lives;
    to_over   = play && (lives_nxt == 2'd0);
    to_win    = play && (kills_nxt == WIN_KILLS);
  end

`ifdef ENEMY_KILL_COMBO_EN
  localparam int TW = $clog2(COMBO_WINDOW + 1);
  localparam logic [TW-1:0] CW = TW'(COMBO_WINDOW);

  logic [TW-1:0] timer;

  assign pts = (timer < CW)
             ? bcd_add(POINTS_PER_KILL, POINTS_PER_KILL)
             : POINTS_PER_KILL;

  // Frames since the last scored kill, saturating at the window.
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      timer <= CW;
    end else if (!play && restart) begin
      timer <= CW;
    end else if (any_kill) begin
      timer <= '0;
    end else if (refresh_tick && timer < CW) begin
      timer <= timer + TW'(1);
    end
  end
`else
  logic unused_tick;

  assign unused_tick = refresh_tick;
  assign pts         = POINTS_PER_KILL;
`endif

  // Input history, per-enemy arming and the pending-kill buffer.
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      ed_prev   <= '0;
      tank_prev <= 1'b0;
      armed     <= '1;
      pend      <= '0;
    end else begin
      ed_prev   <= enemy_detroyed;
      tank_prev <= tank_detroyed;
      if (!play && restart) armed <= '1;
      else                  armed <= armed_nxt;
      if (!play || to_over || to_win) pend <= '0;
      else                            pend <= cand & ~sel;
    end
  end

  // Game FSM with registered score, kills, lives and pulse outputs.
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      state       <= PLAY;
      game_active <= 1'b1;
      score_bcd   <= '0;
      kills       <= '0;
      lives       <= LIVES_RST;
      kill_pulse  <= '0;
    end else begin
      unique case (state)
        PLAY: begin
          kill_pulse <= any_kill ? sel : '0;
          if (any_kill) score_bcd <= score_sum;
          kills <= kills_nxt;
          lives <= lives_nxt;
          if (to_over) begin
            state       <= OVER;
            game_active <= 1'b0;
          end else if (to_win) begin
            state       <= WIN;
            game_active <= 1'b0;
          end
        end
        default: begin
          kill_pulse <= '0;
          if (restart) begin
            state       <= PLAY;
            game_active <= 1'b1;
            score_bcd   <= '0;
            kills       <= '0;
            lives       <= LIVES_RST;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_kill_tracker.sv
// tb_enemy_kill_tracker: directed scenarios plus random play,
// scoreboarded against a decimal reference model of the game rules.
module tb_enemy_kill_tracker;

  localparam int          N    = 3;
  localparam int          KTW  = 120;
  localparam int          LIV  = 3;
  localparam logic [15:0] PTS  = 16'h0101;
  localparam int          PDEC = 101;
  localparam int          CWIN = 60;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic        restart;
  logic [2:0]  ed;
  logic [2:0]  rl;
  logic        td;
  logic [15:0] score_bcd;
  logic [7:0]  kills;
  logic [1:0]  lives;
  logic [1:0]  game_state;
  logic        game_active;
  logic [2:0]  kill_pulse;

  int n_chk = 0;
  int n_fail = 0;

  enemy_kill_tracker #(
    .N_ENEMY(N),
    .KILLS_TO_WIN(KTW),
    .LIVES_INIT(LIV),
    .POINTS_PER_KILL(PTS),
    .COMBO_WINDOW(CWIN)
  ) dut (
    .clk_50MHz(clk),
    .reset(rst_n),
    .refresh_tick(tick),
    .restart(restart),
    .enemy_detroyed(ed),
    .reset_loc(rl),
    .tank_detroyed(td),
    .score_bcd(score_bcd),
    .kills(kills),
    .lives(lives),
    .game_state(game_state),
    .game_active(game_active),
    .kill_pulse(kill_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int to_bcd(input int v);
    return ((v / 1000) << 12) | (((v / 100) % 10) << 8)
         | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  // Reference model: decimal score, per-enemy flags, a pending set.
  int m_prev[N];
  int m_armed[N];
  int m_pend[N];
  int m_tprev;
  int m_score;
  int m_kills;
  int m_lives;
  int m_state;
  int m_timer;
  int exp_q[$];

  task automatic model_round();
    m_score = 0;
    m_kills = 0;
    m_lives = LIV;
    m_state = 0;
    m_timer = CWIN;
    for (int i = 0; i < N; i++) begin
      m_armed[i] = 1;
      m_pend[i]  = 0;
    end
  endtask

  task automatic model_reset();
    model_round();
    m_tprev = 0;
    for (int i = 0; i < N; i++) m_prev[i] = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    int rise[N];
    int acc[N];
    int srv;
    int trise;
    int st0;
    int pts;
    st0   = m_state;
    srv   = -1;
    trise = (td && !m_tprev) ? 1 : 0;
    for (int i = 0; i < N; i++) begin
      rise[i] = (ed[i] && !m_prev[i]) ? 1 : 0;
      acc[i]  = 0;
    end
    if (st0 == 0) begin
      for (int i = 0; i < N; i++)
        if (rise[i] && m_armed[i]) begin
          acc[i]    = 1;
          m_pend[i] = 1;
        end
      for (int i = 0; i < N; i++)
        if (srv < 0 && m_pend[i]) srv = i;
      if (srv >= 0) begin
        pts = PDEC;
`ifdef ENEMY_KILL_COMBO_EN
        if (m_timer < CWIN) pts = 2 * PDEC;
`endif
        m_pend[srv] = 0;
        m_score = (m_score + pts > 9999) ? 9999 : m_score + pts;
        m_kills = (m_kills == 255) ? 255 : m_kills + 1;
        exp_q.push_back(1 << srv);
      end
      if (trise && m_lives > 0) m_lives--;
      if (m_lives == 0 || m_kills == KTW) begin
        m_state = (m_lives == 0) ? 2 : 1;
        for (int i = 0; i < N; i++) m_pend[i] = 0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (acc[i]) m_armed[i] = 0;
      else if (rl[i] && !rise[i]) m_armed[i] = 1;
    end
    if (st0 != 0 && restart) model_round();
    else if (srv >= 0) m_timer = 0;
    else if (tick && m_timer < CWIN) m_timer++;
    for (int i = 0; i < N; i++) m_prev[i] = ed[i];
    m_tprev = td;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Scoreboard monitor for scored kills.
  always @(negedge clk) begin
    int e;
    if (kill_pulse != 3'b000 || exp_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 0;
      chk("kill_pulse", int'(kill_pulse), e);
    end
  end

  // Per-cycle comparison of the round state against the model.
  always @(negedge clk) begin
    chk("score", int'(score_bcd), to_bcd(m_score));
    chk("kills", int'(kills), m_kills);
    chk("lives", int'(lives), m_lives);
    chk("state", int'(game_state), m_state);
    chk("active", int'(game_active), (m_state == 0) ? 1 : 0);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    tick = 1'b0;
    restart = 1'b0;
    ed = '0;
    rl = '0;
    td = 1'b0;
    cyc();
    @(negedge clk);
    chk("rst_score", int'(score_bcd), 0);
    chk("rst_kills", int'(kills), 0);
    chk("rst_lives", int'(lives), 3);
    chk("rst_state", int'(game_state), 0);
    chk("rst_active", int'(game_active), 1);
    chk("rst_pulse", int'(kill_pulse), 0);
    cyc();
    rst_n = 1'b1;

    // T1: long level holds give one kill, one clock later.
    ed = 3'b001;
    cyc();
    @(negedge clk);
    chk("t1_pulse", int'(kill_pulse), 1);
    chk("t1_kills", int'(kills), 1);
    chk("t1_score", int'(score_bcd), 16'h0101);
    repeat (39) cyc();
    chk("t1_once", int'(kills), 1);

    // T2: no re-arm, no count; re-armed, counts.
    ed = 3'b000;
    cyc();
    ed = 3'b001;
    cyc();
    ed = 3'b000;
    cyc();
    @(negedge clk);
    chk("t2_unarmed", int'(kills), 1);
    rl = 3'b001;
    cyc();
    rl = 3'b000;
    ed = 3'b001;
    cyc();
    @(negedge clk);
    chk("t2_rearmed", int'(kills), 2);
    ed = 3'b000;
    cyc();

    // T3: simultaneous kills are serviced lowest index first.
    rl = 3'b111;
    cyc();
    rl = 3'b000;
    ed = 3'b111;
    cyc();
    @(negedge clk);
    chk("t3_p0", int'(kill_pulse), 3'b001);
    cyc();
    @(negedge clk);
    chk("t3_p1", int'(kill_pulse), 3'b010);
    cyc();
    @(negedge clk);
    chk("t3_p2", int'(kill_pulse), 3'b100);
    chk("t3_kills", int'(kills), 5);
`ifndef ENEMY_KILL_COMBO_EN
    chk("t3_score", int'(score_bcd), 16'h0505);
`endif
    ed = 3'b000;
    cyc();

    // T4: three tank hits end the round; kills freeze; restart.
    for (int k = 0; k < 3; k++) begin
      td = 1'b1;
      cyc();
      td = 1'b0;
      @(negedge clk);
      chk("t4_lives", int'(lives), 2 - k);
      cyc();
    end
    chk("t4_state", int'(game_state), 2);
    chk("t4_active", int'(game_active), 0);
    rl = 3'b111;
    cyc();
    rl = 3'b000;
    ed = 3'b010;
    cyc();
    ed = 3'b000;
    cyc();
    @(negedge clk);
    chk("t4_frozen", int'(kills), 5);
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    @(negedge clk);
    chk("t4_rs_state", int'(game_state), 0);
    chk("t4_rs_lives", int'(lives), 3);
    chk("t4_rs_score", int'(score_bcd), 0);
    chk("t4_rs_kills", int'(kills), 0);

    // T5: saturate the score, then reach the win count.
    for (int k = 1; k <= KTW; k++) begin
      ed[0] = 1'b1;
      cyc();
      ed[0] = 1'b0;
      rl[0] = 1'b1;
      cyc();
      rl[0] = 1'b0;
      if (k == 99 || k == 100) begin
        @(negedge clk);
        chk("t5_sat", int'(score_bcd), 16'h9999);
        chk("t5_kills", int'(kills), k);
      end
    end
    @(negedge clk);
    chk("t5_state", int'(game_state), 1);
    chk("t5_active", int'(game_active), 0);
    chk("t5_win_kills", int'(kills), KTW);
    restart = 1'b1;
    cyc();
    restart = 1'b0;

    // Random play with a mid-round reset.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) ed[i] = ~ed[i];
        rl[i] = ($urandom_range(0, 5) == 0);
      end
      td = ($urandom_range(0, 299) == 0);
      tick = ($urandom_range(0, 3) == 0);
      if (m_state != 0) restart = ($urandom_range(0, 9) == 0);
      else              restart = ($urandom_range(0, 49) == 0);
      if (c == 1500) rst_n = 1'b0;
      if (c == 1502) rst_n = 1'b1;
      cyc();
    end

    ed = '0;
    rl = '0;
    td = 1'b0;
    tick = 1'b0;
    restart = 1'b0;
    repeat (6) cyc();
    @(negedge clk);
    chk("drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
